y86_pipe_controller: RTL and testbench

- Centralised hazard and sequencing controller for the 5-stage Y86 pipeline.
- Consumes stage icodes, register IDs, branch condition and stage status codes.
- Drives the stall and bubble controls of the F/D/E/M/W pipeline registers.
- Owns a run-state FSM: post-reset flush, run, and stopped-on-exception. It also owns a cycle counter and a retirement counter.

---
 rtl/y86_pkg.sv | 32 +++
 rtl/y86_hazard_detect.sv | 36 +++
 rtl/y86_pipe_controller.sv | 153 +++++++++++++++
 tb/tb_y86_pipe_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings: icodes, register IDs, status codes and the
// controller run-state encoding. Reused by the fetch/decode/execute blocks.
package y86_pkg;

   localparam int unsigned ICODE_W = 4;
   localparam int unsigned REG_W   = 4;
   localparam int unsigned STAT_W  = 3;

   // Instruction codes the pipeline controller cares about
   localparam logic [ICODE_W-1:0] NOP    = 4'h1;
   localparam logic [ICODE_W-1:0] MRMOVQ = 4'h5;
   localparam logic [ICODE_W-1:0] JXX    = 4'h7;
   localparam logic [ICODE_W-1:0] RET    = 4'h9;
   localparam logic [ICODE_W-1:0] POPQ   = 4'hB;

   // "No register" marker
   localparam logic [REG_W-1:0] RNONE = 4'hF;

   // Status codes; anything other than AOK is abnormal
   localparam logic [STAT_W-1:0] STAT_AOK = 3'd0;
   localparam logic [STAT_W-1:0] STAT_HLT = 3'd1;
   localparam logic [STAT_W-1:0] STAT_ADR = 3'd2;
   localparam logic [STAT_W-1:0] STAT_INS = 3'd3;

   // Controller run state; encoding 3 is illegal and recovers to flush
   typedef enum logic [1:0] {
      RS_FLUSH   = 2'd0,
      RS_RUN     = 2'd1,
      RS_STOPPED = 2'd2
   } run_state_t;

endpackage

// File: rtl/y86_hazard_detect.sv
// Purely combinational Y86 pipeline hazard terms.
module y86_hazard_detect
   import y86_pkg::*;
(
   input  logic [ICODE_W-1:0] D_icode,
   input  logic [ICODE_W-1:0] E_icode,
   input  logic [ICODE_W-1:0] M_icode,
   input  logic               e_Cnd,
   input  logic [REG_W-1:0]   E_dstM,
   input  logic [REG_W-1:0]   d_srcA,
   input  logic [REG_W-1:0]   d_srcB,
   input  logic [STAT_W-1:0]  m_stat,
   input  logic [STAT_W-1:0]  W_stat,
   output logic               load_use,
   output logic               ret_in,
   output logic               mispred,
   output logic               m_exc,
   output logic               w_exc
);

   // Load in E whose destination is read by the instruction in D
   assign load_use = ((E_icode == MRMOVQ) || (E_icode == POPQ)) &&
                     (E_dstM != RNONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));

   // Return travelling through D, E or M: next PC not yet known
   assign ret_in = (D_icode == RET) || (E_icode == RET) || (M_icode == RET);

   // Conditional jump predicted taken but found not taken
   assign mispred = (E_icode == JXX) && !e_Cnd;

   // Exceptions in memory and write-back stages
   assign m_exc = (m_stat != STAT_AOK);
   assign w_exc = (W_stat != STAT_AOK);

endmodule

// File: rtl/y86_pipe_controller.sv
// Y86 5-stage pipeline controller: hazard stall/bubble generation, post-reset
// flush, stop-on-exception, cycle and retirement counters.
// Optional perf counters (stall/ret/mispred) enabled by PIPE_CTRL_PERF_EN.
module y86_pipe_controller
   import y86_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 5,
   parameter int unsigned CNT_W        = 32
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [ICODE_W-1:0] D_icode,
   input  logic [ICODE_W-1:0] E_icode,
   input  logic [ICODE_W-1:0] M_icode,
   input  logic [ICODE_W-1:0] W_icode,
   input  logic               e_Cnd,
   input  logic [REG_W-1:0]   E_dstM,
   input  logic [REG_W-1:0]   d_srcA,
   input  logic [REG_W-1:0]   d_srcB,
   input  logic [STAT_W-1:0]  m_stat,
   input  logic [STAT_W-1:0]  W_stat,
   output logic               F_stall,
   output logic               D_stall,
   output logic               D_bubble,
   output logic               E_bubble,
   output logic               M_bubble,
   output logic               W_stall,
   output logic               pc_init,
   output logic               set_cc_inhibit,
   output logic [1:0]         run_state,
   output logic               done,
   output logic [STAT_W-1:0]  final_stat,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [CNT_W-1:0]   retire_cnt
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   ret_cnt,
   output logic [CNT_W-1:0]   mispred_cnt
`endif
);

   localparam int unsigned FCNT_W = 4;

   run_state_t        state;
   logic [FCNT_W-1:0] flush_cnt;
   logic              load_use;
   logic              ret_in;
   logic              mispred;
   logic              m_exc;
   logic              w_exc;

   y86_hazard_detect u_hazard (
      .D_icode  (D_icode),
      .E_icode  (E_icode),
      .M_icode  (M_icode),
      .e_Cnd    (e_Cnd),
      .E_dstM   (E_dstM),
      .d_srcA   (d_srcA),
      .d_srcB   (d_srcB),
      .m_stat   (m_stat),
      .W_stat   (W_stat),
      .load_use (load_use),
      .ret_in   (ret_in),
      .mispred  (mispred),
      .m_exc    (m_exc),
      .w_exc    (w_exc)
   );

   assign run_state = state;

   // Run-state FSM, flush countdown, stop latching and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RS_FLUSH;
         flush_cnt   <= FCNT_W'(FLUSH_CYCLES - 1);
         cycle_cnt   <= '0;
         retire_cnt  <= '0;
         done        <= 1'b0;
         final_stat  <= STAT_AOK;
`ifdef PIPE_CTRL_PERF_EN
         stall_cnt   <= '0;
         ret_cnt     <= '0;
         mispred_cnt <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            RS_FLUSH: begin
               if (flush_cnt == '0) state <= RS_RUN;
               else                 flush_cnt <= flush_cnt - FCNT_W'(1);
            end
            RS_RUN: begin
               cycle_cnt <= cycle_cnt + CNT_W'(1);
               if ((W_stat == STAT_AOK) && (W_icode != NOP))
                  retire_cnt <= retire_cnt + CNT_W'(1);
`ifdef PIPE_CTRL_PERF_EN
               if (load_use)            stall_cnt   <= stall_cnt + CNT_W'(1);
               if (ret_in && !load_use) ret_cnt     <= ret_cnt + CNT_W'(1);
               if (mispred)             mispred_cnt <= mispred_cnt + CNT_W'(1);
`endif
               if (w_exc) begin
                  state      <= RS_STOPPED;
                  final_stat <= W_stat;
                  done       <= 1'b1;
               end
            end
            RS_STOPPED: ;
            default: begin
               state     <= RS_FLUSH;
               flush_cnt <= FCNT_W'(FLUSH_CYCLES - 1);
            end
         endcase
      end
   end

   // Pipeline register controls, zero latency from hazard inputs
   always_comb begin
      F_stall        = 1'b0;
      D_stall        = 1'b0;
      D_bubble       = 1'b0;
      E_bubble       = 1'b0;
      M_bubble       = 1'b0;
      W_stall        = 1'b0;
      pc_init        = 1'b0;
      set_cc_inhibit = 1'b0;
      case (state)
         RS_RUN: begin
            F_stall        = load_use || ret_in;
            D_stall        = load_use;
            D_bubble       = mispred || (!load_use && ret_in);
            E_bubble       = mispred || load_use;
            M_bubble       = m_exc || w_exc;
            W_stall        = w_exc;
            set_cc_inhibit = m_exc || w_exc;
         end
         RS_STOPPED: begin
            F_stall        = 1'b1;
            D_stall        = 1'b1;
            W_stall        = 1'b1;
            set_cc_inhibit = 1'b1;
         end
         default: begin
            pc_init        = 1'b1;
            D_bubble       = 1'b1;
            E_bubble       = 1'b1;
            M_bubble       = 1'b1;
            set_cc_inhibit = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_y86_pipe_controller.sv
// Scoreboard bench for y86_pipe_controller: directed scenarios plus random
// traffic, expected values from a behavioural model of the controller rules.
module tb_y86_pipe_controller;

   localparam int unsigned FLUSH_CYCLES = 5;
   localparam int unsigned CNT_W        = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       d_icode, e_icode, m_icode, w_icode;
   logic             e_cnd;
   logic [3:0]       e_dst_m, d_src_a, d_src_b;
   logic [2:0]       m_stat, w_stat;

   logic             f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall;
   logic             pc_init, cc_inh, done;
   logic [1:0]       run_state;
   logic [2:0]       final_stat;
   logic [CNT_W-1:0] cycle_cnt, retire_cnt;
   logic [CNT_W-1:0] stall_cnt, ret_cnt, mispred_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   y86_pipe_controller #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .D_icode(d_icode), .E_icode(e_icode), .M_icode(m_icode), .W_icode(w_icode),
      .e_Cnd(e_cnd), .E_dstM(e_dst_m), .d_srcA(d_src_a), .d_srcB(d_src_b),
      .m_stat(m_stat), .W_stat(w_stat),
      .F_stall(f_stall), .D_stall(d_stall), .D_bubble(d_bubble),
      .E_bubble(e_bubble), .M_bubble(m_bubble), .W_stall(w_stall),
      .pc_init(pc_init), .set_cc_inhibit(cc_inh), .run_state(run_state),
      .done(done), .final_stat(final_stat),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`ifdef PIPE_CTRL_PERF_EN
      , .stall_cnt(stall_cnt), .ret_cnt(ret_cnt), .mispred_cnt(mispred_cnt)
`endif
   );

`ifndef PIPE_CTRL_PERF_EN
   assign stall_cnt   = '0;
   assign ret_cnt     = '0;
   assign mispred_cnt = '0;
`endif

   // Expected response for one cycle; ctl = {pc_init,F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,cc_inhibit}
   typedef struct {
      logic [7:0]       ctl;
      logic [1:0]       rs;
      logic             done;
      logic [2:0]       fstat;
      logic [CNT_W-1:0] cyc, ret, sc, rc, mc;
   } exp_t;

   exp_t exp_q[$];

   // Behavioural model state: mode 0=flush, 1=run, 2=stopped, -1=not yet reset
   int               mode = -1;
   int               flush_left;
   logic             m_done;
   logic [2:0]       m_fstat;
   logic [CNT_W-1:0] m_cyc, m_ret, m_sc, m_rc, m_mc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
      end
   endtask

   // Compute this cycle's expectation, queue it, then advance the model over the coming edge
   task automatic step(input logic r);
      bit lu, ri, mp, me, we;
      exp_t e;
      rst = r;
      lu = (e_icode == 4'd5 || e_icode == 4'd11) && e_dst_m != 4'hF &&
           (e_dst_m == d_src_a || e_dst_m == d_src_b);
      ri = (d_icode == 4'd9) || (e_icode == 4'd9) || (m_icode == 4'd9);
      mp = (e_icode == 4'd7) && !e_cnd;
      me = (m_stat != 3'd0);
      we = (w_stat != 3'd0);
      if (mode >= 0) begin
         if (mode == 0)      e.ctl = 8'b1001_1101;
         else if (mode == 2) e.ctl = 8'b0110_0011;
         else e.ctl = {1'b0, lu || ri, lu, mp || (ri && !lu), mp || lu, me || we, we, me || we};
         e.rs    = 2'(mode);
         e.done  = m_done;
         e.fstat = m_fstat;
         e.cyc   = m_cyc;
         e.ret   = m_ret;
         e.sc    = m_sc;
         e.rc    = m_rc;
         e.mc    = m_mc;
         exp_q.push_back(e);
      end
      if (r) begin
         mode = 0; flush_left = FLUSH_CYCLES - 1;
         m_done = 0; m_fstat = 0;
         m_cyc = 0; m_ret = 0; m_sc = 0; m_rc = 0; m_mc = 0;
      end else if (mode == 0) begin
         m_done = 0;
         if (flush_left == 0) mode = 1;
         else flush_left--;
      end else if (mode == 1) begin
         m_cyc++;
         if (!we && w_icode != 4'd1) m_ret++;
         if (lu) m_sc++;
         if (ri && !lu) m_rc++;
         if (mp) m_mc++;
         m_done = we;
         if (we) begin
            mode = 2;
            m_fstat = w_stat;
         end
      end else begin
         m_done = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      d_icode = 4'd1; e_icode = 4'd1; m_icode = 4'd1; w_icode = 4'd1;
      e_cnd = 1'b1; e_dst_m = 4'hF; d_src_a = 4'hF; d_src_b = 4'hF;
      m_stat = 3'd0; w_stat = 3'd0;
   endtask

   function automatic logic [3:0] rand_icode();
      case ($urandom_range(0, 6))
         0: return 4'd1;
         1: return 4'd5;
         2: return 4'd7;
         3: return 4'd9;
         4: return 4'd11;
         5: return 4'd6;
         default: return 4'($urandom_range(0, 15));
      endcase
   endfunction

   function automatic logic [3:0] rand_reg();
      int v;
      v = $urandom_range(0, 4);
      return (v == 4) ? 4'hF : 4'(v);
   endfunction

   task automatic set_random();
      d_icode = rand_icode(); e_icode = rand_icode();
      m_icode = rand_icode(); w_icode = rand_icode();
      e_cnd   = 1'($urandom_range(0, 1));
      e_dst_m = rand_reg(); d_src_a = rand_reg(); d_src_b = rand_reg();
      m_stat  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 3)) : 3'd0;
      w_stat  = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(1, 3)) : 3'd0;
   endtask

   // Monitor: pop the expectation for the current cycle and compare away from the edge
   exp_t mon_e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("ctl", 64'({pc_init, f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, cc_inh}), 64'(mon_e.ctl));
         chk("run_state", 64'(run_state), 64'(mon_e.rs));
         chk("done", 64'(done), 64'(mon_e.done));
         chk("final_stat", 64'(final_stat), 64'(mon_e.fstat));
         chk("cycle_cnt", 64'(cycle_cnt), 64'(mon_e.cyc));
         chk("retire_cnt", 64'(retire_cnt), 64'(mon_e.ret));
`ifdef PIPE_CTRL_PERF_EN
         chk("stall_cnt", 64'(stall_cnt), 64'(mon_e.sc));
         chk("ret_cnt", 64'(ret_cnt), 64'(mon_e.rc));
         chk("mispred_cnt", 64'(mispred_cnt), 64'(mon_e.mc));
`endif
      end
   end

   initial begin
      set_nop();
      step(1'b1);
      step(1'b1);
      // Flush then a few quiet RUN cycles
      repeat (8) step(1'b0);
      // Load/use hazard, then the same with RNONE
      e_icode = 4'd5; e_dst_m = 4'd3; d_src_a = 4'd3;
      repeat (2) step(1'b0);
      e_dst_m = 4'hF; d_src_a = 4'hF;
      step(1'b0);
      // Mispredicted and correctly predicted jump
      set_nop(); e_icode = 4'd7; e_cnd = 1'b0;
      step(1'b0);
      e_cnd = 1'b1;
      step(1'b0);
      // Return in D coinciding with a popq load/use
      set_nop(); d_icode = 4'd9; e_icode = 4'd11; e_dst_m = 4'd2; d_src_b = 4'd2;
      repeat (3) step(1'b0);
      // Mispredict together with load/use is impossible (same E), so pair ret+mispred
      set_nop(); m_icode = 4'd9; e_icode = 4'd7; e_cnd = 1'b0;
      step(1'b0);
      // Ten retirements, then halt
      set_nop(); w_icode = 4'd6;
      repeat (10) step(1'b0);
      w_stat = 3'd1;
      step(1'b0);
      repeat (20) begin
         set_random();
         step(1'b0);
      end
      // Reset out of STOPPED, flush again, then four load/use cycles
      set_nop();
      step(1'b1);
      repeat (8) step(1'b0);
      e_icode = 4'd5; e_dst_m = 4'd1; d_src_a = 4'd1;
      repeat (4) step(1'b0);
      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         set_random();
         step($urandom_range(0, 99) == 0);
      end
      set_nop();
      step(1'b0);
      @(negedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
